// File: rtl/sass_pkg.sv
// Shared constants and FSM encoding for the SASS serial transmitter family.
package sass_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

endpackage

// File: rtl/sass_fifo.sv
// Show-ahead word FIFO: dout always presents the head entry; pushes into a full
// FIFO and pops from an empty one are ignored.
module sass_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       din,
  output logic [width-1:0]       dout,
  output logic [$clog2(depth):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(depth);
  localparam int LW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(depth));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sass_tx_fifo.sv
// SASS serial transmitter with word FIFO, optional parity, 1/2 stop bits and
// bit-order selection; frames are chained back-to-back while words are queued.
module sass_tx_fifo
  import sass_pkg::*;
#(
  parameter int frame_l   = 8,
  parameter int t         = 100,
  parameter int depth     = 4,
  parameter int parity    = 0,
  parameter int stop_b    = 1,
  parameter int msb_first = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  logic [frame_l-1:0]     data,
  output logic                   ready,
  output logic                   busy,
  output logic                   s,
  output logic [$clog2(depth):0] level,
  output logic                   tx_done
);

  localparam int BW = $clog2(t);
  localparam int CW = $clog2(frame_l + 2);
  localparam logic [BW-1:0] BAUD_LAST = BW'(t - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(frame_l - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(stop_b - 1);

  state_t             state, state_d;
  logic [BW-1:0]      baud, baud_d;
  logic [CW-1:0]      bit_cnt, bit_d;
  logic [frame_l-1:0] shreg, shreg_d, shreg_next, head;
  logic               par_acc, par_d, s_d, busy_d, done_d;
  logic               pop, full, empty, baud_end;

  sass_fifo #(.width(frame_l), .depth(depth)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (send),
    .pop  (pop),
    .din  (data),
    .dout (head),
    .level(level),
    .full (full),
    .empty(empty)
  );

  function automatic logic out_bit(input logic [frame_l-1:0] v);
    return (msb_first != 0) ? v[frame_l-1] : v[0];
  endfunction

  assign ready      = !full;
  assign baud_end   = (baud == BAUD_LAST);
  assign shreg_next = (msb_first != 0) ? (shreg << 1) : (shreg >> 1);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state;
    baud_d  = baud_end ? '0 : baud + 1'b1;
    bit_d   = bit_cnt;
    shreg_d = shreg;
    par_d   = par_acc;
    s_d     = s;
    busy_d  = busy;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          shreg_d = head;
          par_d   = 1'b0;
          s_d     = LINE_START;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          s_d     = out_bit(shreg);
        end
      end
      DATA: begin
        if (baud_end) begin
          par_d = par_acc ^ s;  // s holds the data bit just completed
          if (bit_cnt == DATA_LAST) begin
            bit_d = '0;
            if (parity != PAR_NONE) begin
              state_d = PAR;
              s_d     = par_acc ^ s ^ (parity == PAR_ODD);
            end else begin
              state_d = STOP;
              s_d     = LINE_IDLE;
            end
          end else begin
            bit_d   = bit_cnt + 1'b1;
            shreg_d = shreg_next;
            s_d     = out_bit(shreg_next);
          end
        end
      end
      PAR: begin
        if (baud_end) begin
          state_d = STOP;
          bit_d   = '0;
          s_d     = LINE_IDLE;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (bit_cnt == STOP_LAST) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (!empty) begin
              pop     = 1'b1;
              state_d = START;
              shreg_d = head;
              par_d   = 1'b0;
              s_d     = LINE_START;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      s       <= LINE_IDLE;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_cnt <= bit_d;
      shreg   <= shreg_d;
      par_acc <= par_d;
      s       <= s_d;
      busy    <= busy_d;
      tx_done <= done_d;
    end
  end

endmodule
